filter_peak_detector: RTL and testbench

- Sits directly downstream of the trapezoidal shaping filter.
- Consumes one signed shaped sample per clock and detects pulses by threshold crossing.
- Captures each pulse's maximum amplitude and the timestamp of that maximum.
- Hands completed events to the readout logic over a valid/ready interface, with hold-off, abort and overflow accounting.

---
 rtl/filter_pkg.sv | 31 +++
 rtl/fpd_out_slot.sv | 54 +++++
 rtl/filter_peak_detector.sv | 169 ++++++++++++++++
 tb/tb_filter_peak_detector.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types for the shaping-filter readout chain.
// No logic: widths, sample type, detector state encoding and event record.
// Imported by the peak detector and its output slot.
package filter_pkg;

  // Raw converter width and shaped-filter width. Shaped samples carry
  // 5 bits of headroom over the filter data width.
  localparam int SIZE_ADC_DATA    = 14;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int SAMPLE_W         = SIZE_FILTER_DATA + 5;

  // Widest timestamp an event record can carry.
  localparam int TS_W_MAX = 32;

  // One shaped sample, two's complement.
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Pulse detector states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } pd_state_t;

  // A completed pulse: maximum amplitude and the timestamp of that maximum.
  typedef struct packed {
    sample_t               amp;
    logic [TS_W_MAX-1:0]   tstamp;
  } peak_event_t;

endpackage

// File: rtl/fpd_out_slot.sv
// Single-entry valid/ready holding register for detected peak events.
// Latency: a pushed event is visible on out_vld_o one clock after the push.
// Backpressure: while full and not drained, new pushes are dropped and counted.
module fpd_out_slot
  import filter_pkg::*;
#(
  parameter int DATA_W = 53,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_vld_i,
  input  logic [DATA_W-1:0] push_dat_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [DATA_W-1:0] out_dat_o,
  output logic [CNT_W-1:0]  drop_count_o
);

  logic              vld_q;
  logic [DATA_W-1:0] dat_q;
  logic [CNT_W-1:0]  drop_q;

  // The slot can take a new event if it is empty or is being drained on this
  // very edge; a simultaneous push and pop therefore never loses an event.
  logic slot_free;
  assign slot_free = !vld_q || out_rdy_i;

  // Load, drop or drain the single entry; the drop counter sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push_vld_i && slot_free) begin
        vld_q <= 1'b1;
        dat_q <= push_dat_i;
      end else if (push_vld_i) begin
        // Full and stalled: keep the older event, account for the new one.
        if (drop_q != {CNT_W{1'b1}}) begin
          drop_q <= drop_q + CNT_W'(1);
        end
      end else if (out_rdy_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign out_vld_o    = vld_q;
  assign out_dat_o    = dat_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/filter_peak_detector.sv
// Threshold-crossing pulse detector: captures each pulse's maximum and its timestamp.
// Latency: event valid 2 clocks after the first below-threshold sample is presented.
// Backpressure: one-entry output slot; events arriving while it is stalled are dropped and counted.
module filter_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_W             = 32,
  parameter int HOLDOFF          = 16,
  parameter int MAX_LEN          = 256,
  parameter int CNT_W            = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA+4:0] filter_data,
  input  logic                               enable,
  input  logic signed [SIZE_FILTER_DATA+4:0] threshold,
  output logic                               peak_valid,
  input  logic                               peak_ready,
  output logic signed [SIZE_FILTER_DATA+4:0] peak_amp,
  output logic [TS_W-1:0]                    peak_time,
  output logic [CNT_W-1:0]                   drop_count,
  output logic [CNT_W-1:0]                   pileup_count,
  output logic                               busy
);

  import filter_pkg::*;

  localparam int SW      = SIZE_FILTER_DATA + 5;
  localparam int EV_W    = SW + TS_W;
  // One counter serves both the pulse length and the hold-off interval.
  localparam int LEN_LIM = (MAX_LEN > HOLDOFF) ? MAX_LEN : HOLDOFF;
  localparam int LEN_W   = $clog2(LEN_LIM + 1);

  localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] HOLD_LAST_C = LEN_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  // Input stage
  logic signed [SW-1:0] x_q;
  logic [TS_W-1:0]      ts_q;
  logic [TS_W-1:0]      tag_q;

  // Detector state
  pd_state_t            state_q;
  logic signed [SW-1:0] max_q;
  logic [TS_W-1:0]      max_ts_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_inc;
  logic [CNT_W-1:0]     pileup_q;
  logic                 busy_q;

  // Event hand-off to the output slot
  logic                 above;
  logic                 emit_vld;
  logic [EV_W-1:0]      emit_dat;
  logic [EV_W-1:0]      slot_dat;

  // Register each sample with the free-running timestamp taken on the same
  // edge, so the first sample after reset is tagged 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      ts_q  <= '0;
      tag_q <= '0;
    end else begin
      x_q   <= filter_data;
      tag_q <= ts_q;
      ts_q  <= ts_q + TS_W'(1);
    end
  end

  // Signed compare at full sample width; a negative threshold triggers on baseline.
  assign above   = x_q > threshold;
  assign len_inc = len_q + LEN_W'(1);

  // A pulse ends cleanly when an enabled, armed detector sees the sample fall
  // back to or below threshold; the running maximum is the event.
  assign emit_vld = (state_q == ARMED) && enable && !above;
  assign emit_dat = {max_q, max_ts_q};

  // Pulse tracking FSM: arm on crossing, follow the maximum, then sit out the hold-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      max_q    <= '0;
      max_ts_q <= '0;
      len_q    <= '0;
      pileup_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && above) begin
            state_q  <= ARMED;
            busy_q   <= 1'b1;
            max_q    <= x_q;
            max_ts_q <= tag_q;
            len_q    <= LEN_W'(1);
          end
        end

        ARMED: begin
          if (!enable) begin
            // Abort: the partial pulse is forgotten without any accounting.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            len_q   <= '0;
          end else if (above) begin
            // Strict compare keeps the earliest of equal maxima.
            if (x_q > max_q) begin
              max_q    <= x_q;
              max_ts_q <= tag_q;
            end
            if (len_inc == MAX_LEN_C) begin
              // Too long to be a single pulse: discard as pile-up.
              if (pileup_q != CNT_SAT) begin
                pileup_q <= pileup_q + CNT_W'(1);
              end
              state_q <= filter_pkg::HOLDOFF;
              len_q   <= '0;
            end else begin
              len_q <= len_inc;
            end
          end else begin
            // Falling edge: emit_vld is high this cycle; the slot takes it.
            state_q <= filter_pkg::HOLDOFF;
            len_q   <= '0;
          end
        end

        filter_pkg::HOLDOFF: begin
          // enable is deliberately ignored here so the dead time is always served.
          if (len_q == HOLD_LAST_C) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            len_q   <= '0;
          end else begin
            len_q <= len_inc;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          len_q   <= '0;
        end
      endcase
    end
  end

  fpd_out_slot #(
    .DATA_W (EV_W),
    .CNT_W  (CNT_W)
  ) u_out_slot (
    .clk          (clk),
    .reset        (reset),
    .push_vld_i   (emit_vld),
    .push_dat_i   (emit_dat),
    .out_vld_o    (peak_valid),
    .out_rdy_i    (peak_ready),
    .out_dat_o    (slot_dat),
    .drop_count_o (drop_count)
  );

  assign peak_amp     = slot_dat[EV_W-1 -: SW];
  assign peak_time    = slot_dat[TS_W-1:0];
  assign pileup_count = pileup_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_filter_peak_detector.sv
// Directed bench for filter_peak_detector with small TS_W and MAX_LEN.
// Each section resets the DUT so sample index equals timestamp (mod 16).
// Outputs are sampled 1 time unit after the rising edge.
module tb_filter_peak_detector;

  localparam int SFD     = 16;
  localparam int TS_W    = 4;
  localparam int HOLDOFF = 16;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;

  logic                  clk;
  logic                  reset;
  logic signed [SFD+4:0] filter_data;
  logic                  enable;
  logic signed [SFD+4:0] threshold;
  logic                  peak_valid;
  logic                  peak_ready;
  logic signed [SFD+4:0] peak_amp;
  logic [TS_W-1:0]       peak_time;
  logic [CNT_W-1:0]      drop_count;
  logic [CNT_W-1:0]      pileup_count;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;

  filter_peak_detector #(
    .SIZE_FILTER_DATA (SFD),
    .TS_W             (TS_W),
    .HOLDOFF          (HOLDOFF),
    .MAX_LEN          (MAX_LEN),
    .CNT_W            (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .filter_data  (filter_data),
    .enable       (enable),
    .threshold    (threshold),
    .peak_valid   (peak_valid),
    .peak_ready   (peak_ready),
    .peak_amp     (peak_amp),
    .peak_time    (peak_time),
    .drop_count   (drop_count),
    .pileup_count (pileup_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample, let one rising edge pass, settle.
  task automatic drive(input int v);
    filter_data = 21'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input int v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    threshold   = 21'sd100;
    peak_ready  = 1'b0;
    filter_data = '0;
    #1;
    check("rst_valid",  peak_valid,   0);
    check("rst_amp",    peak_amp,     0);
    check("rst_time",   peak_time,    0);
    check("rst_drop",   drop_count,   0);
    check("rst_pileup", pileup_count, 0);
    check("rst_busy",   busy,         0);
    @(negedge clk);
    reset = 1'b0;

    // Basic pulse: max 300 on ts 4; valid two clocks after the 80 is presented.
    drive(0); drive(0); drive(50); drive(150); drive(300); drive(250); drive(120);
    drive(80);
    check("basic_not_yet", peak_valid, 0);
    drive(0);
    check("basic_valid", peak_valid, 1);
    check("basic_amp",   peak_amp,   300);
    check("basic_time",  peak_time,  4);
    check("basic_busy",  busy,       1);
    peak_ready = 1'b1;
    drive(0);
    check("basic_clear", peak_valid, 0);
    peak_ready = 1'b0;

    // Tie: the first of two equal maxima wins.
    apply_reset();
    drive(0); drive(200); drive(200); drive(90); drive(0);
    check("tie_valid", peak_valid, 1);
    check("tie_amp",   peak_amp,   200);
    check("tie_time",  peak_time,  1);

    // Nothing strictly above threshold, including negatives: no event.
    apply_reset();
    drive(0); drive(100); drive(-500); drive(50); drive(100); drive(-500);
    drive_n(0, 4);
    check("neg_valid", peak_valid, 0);
    check("neg_busy",  busy,       0);

    // Backpressure: second event dropped, third loads on the draining edge.
    apply_reset();
    drive(0); drive(300); drive(0); drive(0);
    check("bp_first_valid", peak_valid, 1);
    drive_n(0, 19);
    drive(400); drive(0); drive(0);
    check("bp_hold_valid", peak_valid, 1);
    check("bp_hold_amp",   peak_amp,   300);
    check("bp_hold_time",  peak_time,  1);
    check("bp_drop",       drop_count, 1);
    drive_n(0, 19);
    drive(500); drive(0);
    peak_ready = 1'b1;
    drive(0);
    check("bp_swap_valid", peak_valid, 1);
    check("bp_swap_amp",   peak_amp,   500);
    check("bp_swap_time",  peak_time,  13);
    check("bp_swap_drop",  drop_count, 1);
    drive(0);
    check("bp_drained", peak_valid, 0);
    peak_ready = 1'b0;

    // Hold-off: crossing 3 cycles after the pulse end is ignored; idx18 is
    // still dead time, idx19 (17 after the end sample) re-arms.
    apply_reset();
    drive(0); drive(200); drive(0); drive(0);
    check("ho_first_amp",  peak_amp,  200);
    check("ho_first_time", peak_time, 1);
    drive(0); drive(200); drive_n(0, 3);
    peak_ready = 1'b1;
    drive(0);
    peak_ready = 1'b0;
    drive_n(0, 8);
    check("ho_ignored_valid", peak_valid, 0);
    check("ho_ignored_drop",  drop_count, 0);
    drive(250); drive(250); drive(0); drive(0);
    check("ho_rearm_valid", peak_valid, 1);
    check("ho_rearm_amp",   peak_amp,   250);
    check("ho_rearm_time",  peak_time,  3);

    // Pile-up: 10 samples above threshold with MAX_LEN 8.
    apply_reset();
    drive(0);
    drive_n(500, 8);
    check("pu_before", pileup_count, 0);
    drive(500);
    check("pu_at_limit", pileup_count, 1);
    check("pu_busy",     busy,         1);
    drive(500);
    drive_n(0, 20);
    check("pu_count", pileup_count, 1);
    check("pu_valid", peak_valid,   0);
    check("pu_drop",  drop_count,   0);
    check("pu_idle",  busy,         0);

    // Abort: enable dropped while armed.
    apply_reset();
    drive(0); drive(300); drive(300);
    check("ab_armed", busy, 1);
    enable = 1'b0;
    drive(300);
    check("ab_busy", busy, 0);
    drive_n(0, 3);
    enable = 1'b1;
    drive_n(0, 3);
    check("ab_valid",  peak_valid,   0);
    check("ab_pileup", pileup_count, 0);
    check("ab_drop",   drop_count,   0);

    // Reset while armed with a pending event discards both.
    apply_reset();
    drive(0); drive(300); drive(0); drive(0);
    drive_n(0, 16);
    drive(400); drive(400);
    check("mr_pre_busy",  busy,       1);
    check("mr_pre_valid", peak_valid, 1);
    reset = 1'b1;
    #1;
    check("mr_valid", peak_valid, 0);
    check("mr_amp",   peak_amp,   0);
    check("mr_time",  peak_time,  0);
    check("mr_busy",  busy,       0);
    @(negedge clk);
    reset = 1'b0;
    drive_n(0, 4);
    check("mr_after_valid", peak_valid, 0);
    check("mr_after_busy",  busy,       0);

    // Timestamp wrap with a 4-bit counter: ts 15, then ts 16 reads as 0.
    apply_reset();
    drive_n(0, 15); drive(300); drive(0); drive(0);
    check("wrap15_amp",  peak_amp,  300);
    check("wrap15_time", peak_time, 15);
    apply_reset();
    drive_n(0, 16); drive(300); drive(0); drive(0);
    check("wrap16_valid", peak_valid, 1);
    check("wrap16_time",  peak_time,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
